vga_trace_plotter: RTL and testbench

//  Parametrised VGA scope: raster timing plus a per-channel sample buffer holding one y value per screen column.

---
 rtl/vga_trace_plotter_pkg.sv | 32 +++
 rtl/vga_trace_plotter_if.sv | 14 +
 rtl/vga_trace_plotter_timing.sv | 66 ++++++
 rtl/vga_trace_plotter.sv | 172 +++++++++++++++++
 tb/tb_vga_trace_plotter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_trace_plotter_pkg.sv
// Shared timing defaults, colour constants and FSM encoding for the VGA trace plotter.
package vga_trace_plotter_pkg;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  localparam logic [2:0] ColBlack = 3'b000;
  localparam logic [2:0] ColWhite = 3'b111;

  typedef enum logic {StClear, StRun} state_e;

  function automatic int unsigned h_total(int unsigned act, int unsigned fp, int unsigned sync,
                                          int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(int unsigned act, int unsigned fp, int unsigned sync,
                                          int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vga_trace_plotter_if.sv
// Sample write channel from the sample producer into the plotter buffer.
interface vga_trace_plotter_if #(
  parameter int unsigned X_W = 10,
  parameter int unsigned Y_W = 9
) ();
  logic           wr_valid;
  logic           wr_ready;
  logic [1:0]     wr_ch;
  logic [X_W-1:0] wr_x;
  logic [Y_W-1:0] wr_y;

  modport master (output wr_valid, wr_ch, wr_x, wr_y, input wr_ready);
  modport slave  (input wr_valid, wr_ch, wr_x, wr_y, output wr_ready);
endinterface

// File: rtl/vga_trace_plotter_timing.sv
// Raster counters with raw syncs, active-video and blanking flags.
module vga_trace_plotter_timing
  import vga_trace_plotter_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter int unsigned HCW      = 10,
  parameter int unsigned VCW      = 10
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  output logic [HCW-1:0] h_cnt_o,
  output logic [VCW-1:0] v_cnt_o,
  output logic           h_sync_o,
  output logic           v_sync_o,
  output logic           active_o,
  output logic           blank_o
);
  localparam int unsigned HTotal = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [HCW-1:0] HLast    = HCW'(HTotal - 1);
  localparam logic [HCW-1:0] HAct     = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HSyncBeg = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HSyncEnd = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCW-1:0] VLast    = VCW'(VTotal - 1);
  localparam logic [VCW-1:0] VAct     = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VSyncBeg = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VSyncEnd = VCW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HCW-1:0] h_q, h_d;
  logic [VCW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == HLast) begin
      h_d = '0;
      v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt_o  = h_q;
  assign v_cnt_o  = v_q;
  assign h_sync_o = ~((h_q >= HSyncBeg) && (h_q < HSyncEnd));
  assign v_sync_o = ~((v_q >= VSyncBeg) && (v_q < VSyncEnd));
  assign active_o = (h_q < HAct) && (v_q < VAct);
  assign blank_o  = ~active_o;

endmodule

// File: rtl/vga_trace_plotter.sv
// Multi-channel VGA scope: per-column sample buffers, trace/cursor compositing, 2-stage pixel pipe.
module vga_trace_plotter
  import vga_trace_plotter_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter int unsigned N_CH     = 2,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9,
  parameter logic [3*N_CH-1:0] CH_COLOR = 6'b010_100
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic [X_W-1:0]      cursor_x_i,
  vga_trace_plotter_if.slave  wr_if,
  output logic [2:0]          rgb_o,
  output logic                h_sync_o,
  output logic                v_sync_o,
  output logic                frame_start_o
);
  localparam int unsigned HCW = max_u(X_W, $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP)));
  localparam int unsigned VCW = max_u(Y_W, $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP)));
  localparam int unsigned AW  = $clog2(H_ACTIVE);
  localparam logic [AW-1:0] AddrLast = AW'(H_ACTIVE - 1);

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           hs_raw, vs_raw, active, blank;

  vga_trace_plotter_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HCW(HCW), .VCW(VCW)
  ) u_timing (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .h_cnt_o  (h_cnt),
    .v_cnt_o  (v_cnt),
    .h_sync_o (hs_raw),
    .v_sync_o (vs_raw),
    .active_o (active),
    .blank_o  (blank)
  );

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [N_CH-1:0] mem_we;
  logic [AW-1:0]  mem_addr;
  logic [Y_W-1:0] mem_wdata;
  logic           wr_hit;

  // Buffer writes only happen while blanking, so they never collide with display reads.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wr_if.wr_ready = 1'b0;
    mem_we         = '0;
    mem_addr       = wr_if.wr_x[AW-1:0];
    mem_wdata      = wr_if.wr_y;
    wr_hit         = wr_if.wr_valid && blank && (wr_if.wr_x < X_W'(H_ACTIVE));
    unique case (state_q)
      StClear: begin
        mem_addr  = addr_q;
        mem_wdata = '1;
        if (clear_i) begin
          addr_d = '0;
        end else if (blank) begin
          mem_we = '1;
          if (addr_q == AddrLast) begin
            state_d = StRun;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      StRun: begin
        wr_if.wr_ready = blank;
        for (int c = 0; c < int'(N_CH); c++) begin
          if (wr_hit && (wr_if.wr_ch == 2'(c))) mem_we[c] = 1'b1;
        end
        if (clear_i) begin
          state_d = StClear;
          addr_d  = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StClear;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  logic [Y_W-1:0] rd_y [N_CH];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [Y_W-1:0] mem_q [H_ACTIVE];
    logic [Y_W-1:0] rd_q;
    always_ff @(posedge clk_i) begin
      if (mem_we[c]) mem_q[mem_addr] <= mem_wdata;
      if (active)    rd_q <= mem_q[h_cnt[AW-1:0]];
    end
    assign rd_y[c] = rd_q;
  end

  logic           hs1_q, vs1_q, act1_q, cur1_q, first1_q, en1_q;
  logic [Y_W-1:0] v1_q;
  logic           hs2_q, vs2_q, fs2_q;
  logic [2:0]     rgb_q, pix_d;

  // Descending scan so the lowest-indexed matching channel wins.
  always_comb begin
    pix_d = ColBlack;
    if (act1_q) begin
      if (cur1_q) begin
        pix_d = ColWhite;
      end else if (en1_q) begin
        for (int c = int'(N_CH) - 1; c >= 0; c--) begin
          if (rd_y[c] == v1_q) pix_d = CH_COLOR[3*c +: 3];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      act1_q   <= 1'b0;
      cur1_q   <= 1'b0;
      first1_q <= 1'b0;
      en1_q    <= 1'b0;
      v1_q     <= '0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      fs2_q    <= 1'b0;
      rgb_q    <= ColBlack;
    end else begin
      hs1_q    <= hs_raw;
      vs1_q    <= vs_raw;
      act1_q   <= active;
      cur1_q   <= (cursor_x_i < X_W'(H_ACTIVE)) && (cursor_x_i == h_cnt[X_W-1:0]);
      first1_q <= (h_cnt == '0) && (v_cnt == '0);
      en1_q    <= (state_q == StRun);
      v1_q     <= v_cnt[Y_W-1:0];
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      fs2_q    <= first1_q;
      rgb_q    <= pix_d;
    end
  end

  assign rgb_o         = rgb_q;
  assign h_sync_o      = hs2_q;
  assign v_sync_o      = vs2_q;
  assign frame_start_o = fs2_q;

endmodule

// File: tb/tb_vga_trace_plotter.sv
// Directed + randomized bench for vga_trace_plotter on a shrunken raster.
module tb_vga_trace_plotter;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 12, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int XW = 5, YW = 4, NCH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear = 1'b0;
  logic [XW-1:0] cursor_x = 5'd31;
  logic [2:0]    rgb;
  logic          hs, vs, fs;

  vga_trace_plotter_if #(.X_W(XW), .Y_W(YW)) wr_if ();

  vga_trace_plotter #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .N_CH(NCH), .X_W(XW), .Y_W(YW), .CH_COLOR(6'b010_100)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .cursor_x_i    (cursor_x),
    .wr_if         (wr_if),
    .rgb_o         (rgb),
    .h_sync_o      (hs),
    .v_sync_o      (vs),
    .frame_start_o (fs)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;
  int ybuf [NCH][HA];
  int col_of [NCH] = '{4, 2};

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  function automatic bit is_active(int p);
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  function automatic int exp_rgb(int p, int cur);
    int h = p % HT;
    int v = p / HT;
    if (!(h < HA && v < VA)) return 0;
    if (cur < HA && h == cur) return 7;
    for (int c = 0; c < NCH; c++) if (ybuf[c][h] == v) return col_of[c];
    return 0;
  endfunction

  function automatic int exp_hs(int p);
    int h = p % HT;
    return (h >= HA + HF && h < HA + HF + HS) ? 0 : 1;
  endfunction

  function automatic int exp_vs(int p);
    int v = p / HT;
    return (v >= VA + VF && v < VA + VF + VS) ? 0 : 1;
  endfunction

  task automatic blank_model();
    for (int c = 0; c < NCH; c++) for (int x = 0; x < HA; x++) ybuf[c][x] = 15;
  endtask

  // Resets, then checks every pin for two full frames including the post-reset clear sweep.
  task automatic reset_and_check_frames();
    int hs_low = 0, vs_low = 0, fs_cnt = 0, rdy_cnt = 0, blanks = 0, p;
    cursor_x = 5'd31;
    blank_model();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rgb", rgb, 0);
    check("rst_hsync", hs, 1);
    check("rst_vsync", vs, 1);
    check("rst_fstart", fs, 0);
    check("rst_ready", wr_if.wr_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 2 * FR; k++) begin
      if (!is_active(n % FR)) blanks++;
      tick();
      if (n < 2) begin
        check("early_rgb", rgb, 0);
        check("early_hsync", hs, 1);
        check("early_vsync", vs, 1);
        check("early_fstart", fs, 0);
      end else begin
        p = (n - 2) % FR;
        check("raster_rgb", rgb, exp_rgb(p, 31));
        check("raster_hsync", hs, exp_hs(p));
        check("raster_vsync", vs, exp_vs(p));
        check("raster_fstart", fs, (p == 0) ? 1 : 0);
        if (n < FR + 2) begin
          hs_low += (hs == 1'b0) ? 1 : 0;
          vs_low += (vs == 1'b0) ? 1 : 0;
          fs_cnt += (fs == 1'b1) ? 1 : 0;
        end
      end
      check("ready_sweep", wr_if.wr_ready, (blanks >= HA && !is_active(n % FR)) ? 1 : 0);
      if (n >= FR) rdy_cnt += (wr_if.wr_ready == 1'b1) ? 1 : 0;
    end
    check("hsync_low_count", hs_low, HS * VT);
    check("vsync_low_count", vs_low, VS * HT);
    check("fstart_count", fs_cnt, 1);
    check("ready_count", rdy_cnt, FR - HA * VA);
  endtask

  task automatic do_write(int ch, int x, int y, output int acc_pos);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_ch    = ch[1:0];
    wr_if.wr_x     = x[XW-1:0];
    wr_if.wr_y     = y[YW-1:0];
    acc_pos = -1;
    for (int k = 0; k < 4 * HT && acc_pos < 0; k++) begin
      if (wr_if.wr_ready === 1'b1) acc_pos = n % FR;
      tick();
    end
    wr_if.wr_valid = 1'b0;
    if (acc_pos < 0) begin
      check("write_timeout", 0, 1);
    end else begin
      check("write_in_blank", is_active(acc_pos), 0);
      if (ch < NCH && x < HA) ybuf[ch][x] = y;
    end
  endtask

  // Checks the first complete frame whose pixels are all sampled after this call.
  task automatic check_frame(string tag, int cur);
    cursor_x = cur[XW-1:0];
    tick();
    while ((n % FR) != 1) tick();
    repeat (FR) begin
      tick();
      check(tag, rgb, exp_rgb((n - 2) % FR, cur));
    end
  endtask

  initial begin
    int acc;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_ch    = '0;
    wr_if.wr_x     = '0;
    wr_if.wr_y     = '0;
    #2;

    reset_and_check_frames();

    // Same sample on both channels: channel 0 has priority.
    do_write(0, 10, 5, acc);
    do_write(1, 10, 5, acc);
    check_frame("overlap_frame", 31);

    repeat (12) begin
      do_write($urandom_range(0, 3), $urandom_range(0, HA + 5), $urandom_range(0, VA - 1), acc);
    end
    check_frame("random_frame", 31);

    do_write(1, 7, 3, acc);
    check_frame("cursor_frame", 7);
    check_frame("cursor_off_frame", 20);

    // Request raised mid-line: must wait for the line's blanking.
    while ((n % FR) != 3 * HT + 2) tick();
    do_write(0, $urandom_range(0, HA - 1), $urandom_range(0, VA - 1), acc);
    check("hold_accept_col", acc % HT, HA);
    check("hold_accept_line", acc / HT, 3);
    do_write(3, 5, 1, acc);
    do_write(0, 20, 1, acc);
    check_frame("discard_frame", 31);

    // Clear coinciding with an accepted write.
    acc = -1;
    for (int k = 0; k < 4 * HT && acc < 0; k++) begin
      if (wr_if.wr_ready === 1'b1) acc = n; else tick();
    end
    check("clear_ready_seen", (acc >= 0) ? 1 : 0, 1);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_ch    = 2'd0;
    wr_if.wr_x     = 5'd3;
    wr_if.wr_y     = 4'd2;
    clear          = 1'b1;
    tick();
    wr_if.wr_valid = 1'b0;
    clear          = 1'b0;
    check("ready_after_clear", wr_if.wr_ready, 0);
    blank_model();
    check_frame("cleared_frame", 9);

    // Asynchronous reset while the output is inside the h_sync pulse.
    cursor_x = 5'd31;
    while ((n % FR) != 5 * HT + HA + HF + 3) tick();
    check("pre_reset_hsync", hs, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_hsync", hs, 1);
    check("async_rst_vsync", vs, 1);
    check("async_rst_rgb", rgb, 0);
    check("async_rst_fstart", fs, 0);
    reset_and_check_frames();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
